register_file: RTL and testbench

- Architectural register file with per-register rename status for the Tomasulo core.
- Sits downstream of the reorder buffer's commit path and beside the issue stage.
- At issue, renames rd to the allocating RoB entry and supplies rs1/rs2 operands or tags to the reservation stations.
- At commit, writes the retired value and clears rename status; on flush, drops all rename status.

---
 rtl/register_file_pkg.sv | 19 +
 rtl/regfile_read_port.sv | 50 +++++
 rtl/register_file.sv | 93 +++++++++
 tb/tb_register_file.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared types and sizes for the architectural register file of the Tomasulo core.
// Read ports and the state block both import this package.
package register_file_pkg;

    localparam int ROB_BITS_DEF = 4;
    localparam int REG_NUM      = 32;
    localparam int REG_BITS     = 5;
    localparam int XLEN         = 32;

    typedef logic [REG_BITS-1:0]     reg_idx_t;
    typedef logic [XLEN-1:0]         xlen_t;
    typedef logic [ROB_BITS_DEF-1:0] rob_id_t;

    // x0 is hard-wired: never renamed, never written.
    function automatic logic is_arch_reg(input reg_idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational operand read port with same-cycle commit bypass; zero latency.
// Reflects state before this cycle's issue, so an instruction reading its own rd sees the older producer.
module regfile_read_port
    import register_file_pkg::*;
#(
    parameter int ROB_BITS = ROB_BITS_DEF
) (
    input  reg_idx_t            idx,
    input  logic [REG_NUM-1:0]  busy_vec,
    input  logic [ROB_BITS-1:0] tag_arr   [REG_NUM],
    input  xlen_t               value_arr [REG_NUM],
    input  logic                commit_valid,
    input  reg_idx_t            commit_rd,
    input  logic [ROB_BITS-1:0] commit_rob_id,
    input  xlen_t               commit_value,
    output logic                busy,
    output logic [ROB_BITS-1:0] tag,
    output xlen_t               value
);

    logic                entry_busy;
    logic [ROB_BITS-1:0] entry_tag;
    xlen_t               entry_value;
    logic                bypass_hit;

    assign entry_busy  = busy_vec[idx];
    assign entry_tag   = tag_arr[idx];
    assign entry_value = value_arr[idx];

    // Only the producer the register is currently waiting on may forward.
    assign bypass_hit = commit_valid && (commit_rd == idx) && is_arch_reg(idx)
                        && entry_busy && (entry_tag == commit_rob_id);

    always_comb begin
        busy  = 1'b0;
        tag   = '0;
        value = '0;
        if (is_arch_reg(idx)) begin
            tag = entry_tag;
            if (bypass_hit) begin
                busy  = 1'b0;
                value = commit_value;
            end else begin
                busy  = entry_busy;
                value = entry_value;
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename status: issue renames rd, commit retires values, flush drops renames.
// Reads are combinational; all state holds while rdy_in is low (reset still applies).
module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_BITS = ROB_BITS_DEF
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                issue_valid,
    input  reg_idx_t            issue_rd,
    input  logic [ROB_BITS-1:0] issue_rob_id,
    input  reg_idx_t            rs1,
    input  reg_idx_t            rs2,
    output logic                rs1_busy,
    output logic [ROB_BITS-1:0] rs1_tag,
    output xlen_t               rs1_value,
    output logic                rs2_busy,
    output logic [ROB_BITS-1:0] rs2_tag,
    output xlen_t               rs2_value,
    input  logic                commit_valid,
    input  reg_idx_t            commit_rd,
    input  logic [ROB_BITS-1:0] commit_rob_id,
    input  xlen_t               commit_value,
    input  logic                flush
);

    logic [REG_NUM-1:0]  busy_q;
    logic [ROB_BITS-1:0] tag_q   [REG_NUM];
    xlen_t               value_q [REG_NUM];

    logic commit_en;
    logic issue_en;

    assign commit_en = commit_valid && is_arch_reg(commit_rd);
    assign issue_en  = issue_valid && is_arch_reg(issue_rd) && !flush;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                tag_q[i]   <= '0;
                value_q[i] <= '0;
            end
        end else if (rdy_in) begin
            if (commit_en) begin
                value_q[commit_rd] <= commit_value;
                // A younger producer keeps the register busy if it renamed rd after this one.
                if (tag_q[commit_rd] == commit_rob_id) begin
                    busy_q[commit_rd] <= 1'b0;
                end
            end
            if (flush) begin
                busy_q <= '0;
            end
            // Issue comes last so it overrides a same-cycle commit to the same rd.
            if (issue_en) begin
                busy_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]  <= issue_rob_id;
            end
        end
    end

    regfile_read_port #(.ROB_BITS(ROB_BITS)) u_rd_rs1 (
        .idx           (rs1),
        .busy_vec      (busy_q),
        .tag_arr       (tag_q),
        .value_arr     (value_q),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .busy          (rs1_busy),
        .tag           (rs1_tag),
        .value         (rs1_value)
    );

    regfile_read_port #(.ROB_BITS(ROB_BITS)) u_rd_rs2 (
        .idx           (rs2),
        .busy_vec      (busy_q),
        .tag_arr       (tag_q),
        .value_arr     (value_q),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .busy          (rs2_busy),
        .tag           (rs2_tag),
        .value         (rs2_value)
    );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: stimulus queues expected read-port results, a negedge monitor pops and compares.
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_id;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic [3:0]  rs1_tag;
    logic [31:0] rs1_value;
    logic        rs2_busy;
    logic [3:0]  rs2_tag;
    logic [31:0] rs2_value;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_rob_id;
    logic [31:0] commit_value;
    logic        flush;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        int          port;
        logic        busy;
        logic        chk_tag;
        logic [3:0]  tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];

    always #5 clk_in = ~clk_in;

    register_file #(.ROB_BITS(4)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rob_id  (issue_rob_id),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_busy      (rs1_busy),
        .rs1_tag       (rs1_tag),
        .rs1_value     (rs1_value),
        .rs2_busy      (rs2_busy),
        .rs2_tag       (rs2_tag),
        .rs2_value     (rs2_value),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .flush         (flush)
    );

    // Monitor: read outputs are combinational, so they are valid every cycle at negedge.
    always @(negedge clk_in) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic        a_busy;
            logic [3:0]  a_tag;
            logic [31:0] a_value;
            e       = sb.pop_front();
            a_busy  = (e.port == 1) ? rs1_busy  : rs2_busy;
            a_tag   = (e.port == 1) ? rs1_tag   : rs2_tag;
            a_value = (e.port == 1) ? rs1_value : rs2_value;
            total++;
            if (a_busy !== e.busy) begin
                bad++;
                $display("FAIL %s rs%0d busy: got %0b want %0b", e.name, e.port, a_busy, e.busy);
            end
            total++;
            if (a_value !== e.value) begin
                bad++;
                $display("FAIL %s rs%0d value: got %h want %h", e.name, e.port, a_value, e.value);
            end
            if (e.chk_tag) begin
                total++;
                if (a_tag !== e.tag) begin
                    bad++;
                    $display("FAIL %s rs%0d tag: got %0d want %0d", e.name, e.port, a_tag, e.tag);
                end
            end
        end
    end

    task automatic expect_rd(input string name, input int port, input logic busy,
                             input logic chk_tag, input logic [3:0] tag, input logic [31:0] value);
        exp_t e;
        e.name = name; e.port = port; e.busy = busy;
        e.chk_tag = chk_tag; e.tag = tag; e.value = value;
        sb.push_back(e);
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_rob_id = 0;
        commit_valid = 0; commit_rd = 0; commit_rob_id = 0; commit_value = 0;
        flush = 0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic [3:0] id);
        issue_valid = 1; issue_rd = rd; issue_rob_id = id;
    endtask

    task automatic set_commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v);
        commit_valid = 1; commit_rd = rd; commit_rob_id = id; commit_value = v;
    endtask

    // End the current cycle: the monitor checks at negedge, inputs change 1 after posedge.
    task automatic step();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1; rdy_in = 1; rs1 = 0; rs2 = 0;
        idle();
        step(); step();
        rst_in = 0;

        rs1 = 5; rs2 = 0;
        expect_rd("reset_x5", 1, 0, 1, 4'd0, 32'h0);
        expect_rd("reset_x0", 2, 0, 1, 4'd0, 32'h0);
        set_issue(0, 3);
        step();
        rs1 = 0;
        expect_rd("x0_after_issue", 1, 0, 1, 4'd0, 32'h0);

        // Rename x5; the read in the issue cycle still sees old state.
        rs1 = 5;
        set_issue(5, 2);
        expect_rd("x5_issue_cycle", 1, 0, 0, 4'd0, 32'h0);
        step();
        rs1 = 5;
        expect_rd("x5_renamed", 1, 1, 1, 4'd2, 32'h0);
        step();
        rs1 = 5; rs2 = 5;
        set_commit(5, 2, 32'hDEADBEEF);
        expect_rd("x5_bypass", 1, 0, 0, 4'd0, 32'hDEADBEEF);
        expect_rd("x5_bypass", 2, 0, 0, 4'd0, 32'hDEADBEEF);
        step();
        expect_rd("x5_committed", 1, 0, 1, 4'd2, 32'hDEADBEEF);

        // Older producer retires after a younger rename.
        set_issue(7, 1);
        step();
        set_issue(7, 4);
        step();
        rs1 = 7;
        set_commit(7, 1, 32'h11);
        expect_rd("x7_no_bypass", 1, 1, 1, 4'd4, 32'h0);
        step();
        expect_rd("x7_younger_owns", 1, 1, 1, 4'd4, 32'h11);

        // Issue and commit to x9 together: issue wins busy/tag.
        set_issue(9, 5);
        step();
        rs1 = 9;
        set_issue(9, 6);
        set_commit(9, 5, 32'h22);
        expect_rd("x9_same_cycle_bypass", 1, 0, 0, 4'd0, 32'h22);
        step();
        expect_rd("x9_issue_wins", 1, 1, 1, 4'd6, 32'h22);

        // Flush with concurrent commit and issue.
        set_issue(1, 1); step();
        set_issue(2, 2); step();
        set_issue(3, 3); step();
        rs1 = 3;
        expect_rd("x3_busy_pre_flush", 1, 1, 1, 4'd3, 32'h0);
        flush = 1;
        set_commit(1, 1, 32'h33);
        set_issue(4, 5);
        step();
        rs1 = 1; rs2 = 2;
        expect_rd("flush_x1", 1, 0, 0, 4'd0, 32'h33);
        expect_rd("flush_x2", 2, 0, 0, 4'd0, 32'h0);
        step();
        rs1 = 3; rs2 = 4;
        expect_rd("flush_x3", 1, 0, 0, 4'd0, 32'h0);
        expect_rd("flush_x4_issue_dropped", 2, 0, 1, 4'd0, 32'h0);
        step();
        rs1 = 7; rs2 = 9;
        expect_rd("flush_x7", 1, 0, 1, 4'd4, 32'h11);
        expect_rd("flush_x9", 2, 0, 1, 4'd6, 32'h22);
        step();

        // Stall: nothing updates while rdy_in is low.
        rdy_in = 0;
        for (int c = 0; c < 2; c++) begin
            rs1 = 10; rs2 = 11;
            set_issue(10, 2);
            set_commit(11, 0, 32'h44);
            expect_rd("stall_x10", 1, 0, 1, 4'd0, 32'h0);
            expect_rd("stall_x11", 2, 0, 1, 4'd0, 32'h0);
            step();
        end
        rdy_in = 1;
        set_issue(10, 2);
        set_commit(11, 0, 32'h44);
        step();
        rs1 = 10; rs2 = 11;
        expect_rd("resume_x10", 1, 1, 1, 4'd2, 32'h0);
        expect_rd("resume_x11", 2, 0, 1, 4'd0, 32'h44);
        step();

        // Reset applies even while stalled.
        rdy_in = 0; rst_in = 1;
        step();
        rst_in = 0;
        rs1 = 10; rs2 = 5;
        expect_rd("reset_stalled_x10", 1, 0, 1, 4'd0, 32'h0);
        expect_rd("reset_stalled_x5", 2, 0, 1, 4'd0, 32'h0);
        step();
        rdy_in = 1;
        step();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
